// File: rtl/encoder_frontend.sv
// Quadrature encoder front end: synchronizes and glitch-filters channels A/B,
// then decodes Gray-code transitions into a signed position with error tracking.
module encoder_frontend #(
  parameter int FILT = 4
) (
  input  logic        clk_nano,
  input  logic        reset,
  input  logic        A,
  input  logic        B,
  output logic        a_clean,
  output logic        b_clean,
  output logic        step,
  output logic        dir,
  output logic [31:0] position,
  output logic        err,
  output logic [7:0]  err_cnt
);

  localparam logic [3:0] FILT_CNT = 4'(FILT);

  typedef enum logic {INIT, RUN} state_t;

  state_t     state;
  logic [1:0] init_cnt;
  logic [1:0] raw;
  logic [1:0] synced;
  logic [1:0] clean;
  logic [1:0] prev;

  assign raw     = {A, B};
  assign a_clean = clean[1];
  assign b_clean = clean[0];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic       sync1_reg;
      logic       sync2_reg;
      logic       clean_reg;
      logic [3:0] cnt_reg;

      // Once the opposite level has been held for FILT cycles it is committed,
      // even if the synced input has just moved again.
      always_ff @(posedge clk_nano) begin
        if (reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          clean_reg <= 1'b0;
          cnt_reg   <= 4'd0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          if (state == INIT) begin
            clean_reg <= sync2_reg;
            cnt_reg   <= 4'd0;
          end else if (cnt_reg == FILT_CNT) begin
            clean_reg <= ~clean_reg;
            cnt_reg   <= 4'd0;
          end else if (sync2_reg != clean_reg) begin
            cnt_reg <= cnt_reg + 4'd1;
          end else begin
            cnt_reg <= 4'd0;
          end
        end
      end

      assign synced[gi] = sync2_reg;
      assign clean[gi]  = clean_reg;
    end
  endgenerate

  always_ff @(posedge clk_nano) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= 2'd0;
      prev     <= 2'b00;
      step     <= 1'b0;
      dir      <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= 8'd0;
      position <= 32'd0;
    end else begin
      step <= 1'b0;
      err  <= 1'b0;
      case (state)
        INIT: begin
          // Seed the decoder with the same level the filters are loading.
          prev <= synced;
          if (init_cnt == 2'd2) begin
            state    <= RUN;
            init_cnt <= 2'd0;
          end else begin
            init_cnt <= init_cnt + 2'd1;
          end
        end
        RUN: begin
          prev <= clean;
          case ({prev, clean})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
              step     <= 1'b1;
              dir      <= 1'b1;
              position <= position + 32'd1;
            end
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
              step     <= 1'b1;
              dir      <= 1'b0;
              position <= position - 32'd1;
            end
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: begin
              err <= 1'b1;
              if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
              end
            end
            default: ;
          endcase
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_frontend.sv
// Scoreboard bench for encoder_frontend: the driver queues expected step/err
// events, a negedge monitor pops and compares each one the DUT emits.
module tb_encoder_frontend;

  logic        clk_nano = 1'b0;
  logic        reset = 1'b1;
  logic        A = 1'b0;
  logic        B = 1'b0;
  logic        a_clean;
  logic        b_clean;
  logic        step;
  logic        dir;
  logic [31:0] position;
  logic        err;
  logic [7:0]  err_cnt;

  encoder_frontend #(.FILT(4)) dut (
    .clk_nano (clk_nano),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .a_clean  (a_clean),
    .b_clean  (b_clean),
    .step     (step),
    .dir      (dir),
    .position (position),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  always #5 clk_nano = ~clk_nano;

  typedef struct {
    logic        is_err;
    logic        d;
    logic [31:0] pos;
    logic [7:0]  ecnt;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  step_total = 0;
  int  ev_num = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_nano);
    #1;
  endtask

  task automatic expect_ev(input logic is_err, input logic d, input logic [31:0] pos,
                           input logic [7:0] ecnt);
    ev_t e;
    e.is_err = is_err;
    e.d      = d;
    e.pos    = pos;
    e.ecnt   = ecnt;
    exp_q.push_back(e);
  endtask

  task automatic move(input logic a, input logic b);
    A = a;
    B = b;
    tick(20);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(8);
  endtask

  // Monitor: every step or err pulse must match the oldest queued expectation.
  always @(negedge clk_nano) begin
    if (step || err) begin
      ev_num++;
      if (step) step_total++;
      $display("event %0d: step=%0d err=%0d dir=%0d pos=0x%08h err_cnt=%0d",
               ev_num, step, err, dir, position, err_cnt);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got step=%0d err=%0d pos=0x%08h, expected no event",
                 step, err, position);
      end else begin
        mon_e = exp_q.pop_front();
        check("ev_step", 32'(step), 32'(!mon_e.is_err));
        check("ev_err", 32'(err), 32'(mon_e.is_err));
        check("ev_dir", 32'(dir), 32'(mon_e.d));
        check("ev_position", position, mon_e.pos);
        check("ev_err_cnt", 32'(err_cnt), 32'(mon_e.ecnt));
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int rises;
    int s0;
    logic pa;
    logic [7:0] ec;

    // Reset state
    tick(3);
    check("rst_a_clean", 32'(a_clean), 32'd0);
    check("rst_b_clean", 32'(b_clean), 32'd0);
    check("rst_step", 32'(step), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_dir", 32'(dir), 32'd0);
    check("rst_position", position, 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    reset = 1'b0;
    tick(8);

    // Four forward steps, first one with exact latency checks
    expect_ev(1'b0, 1'b1, 32'd1, 8'd0);
    A = 1'b1;
    @(posedge clk_nano);
    repeat (5) @(posedge clk_nano);
    #1;
    check("a_clean_before_latency", 32'(a_clean), 32'd0);
    @(posedge clk_nano);
    #1;
    check("a_clean_at_latency", 32'(a_clean), 32'd1);
    @(posedge clk_nano);
    #1;
    check("step_after_clean", 32'(step), 32'd1);
    tick(15);
    expect_ev(1'b0, 1'b1, 32'd2, 8'd0);
    move(1'b1, 1'b1);
    expect_ev(1'b0, 1'b1, 32'd3, 8'd0);
    move(1'b0, 1'b1);
    expect_ev(1'b0, 1'b1, 32'd4, 8'd0);
    move(1'b0, 1'b0);
    check("fwd_position", position, 32'd4);
    check("fwd_dir", 32'(dir), 32'd1);
    check("fwd_err_cnt", 32'(err_cnt), 32'd0);
    check("fwd_step_count", 32'(step_total), 32'd4);

    // Two reverse steps from zero, B first
    do_reset();
    s0 = step_total;
    expect_ev(1'b0, 1'b0, 32'hFFFF_FFFF, 8'd0);
    move(1'b0, 1'b1);
    expect_ev(1'b0, 1'b0, 32'hFFFF_FFFE, 8'd0);
    move(1'b1, 1'b1);
    check("rev_position", position, 32'hFFFF_FFFE);
    check("rev_dir", 32'(dir), 32'd0);
    check("rev_step_count", 32'(step_total - s0), 32'd2);

    // Glitch filter: 3-cycle pulse rejected, 4-cycle pulse accepted
    A = 1'b0;
    B = 1'b0;
    do_reset();
    A = 1'b1;
    tick(3);
    A = 1'b0;
    rises = 0;
    pa = a_clean;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (a_clean && !pa) rises++;
      pa = a_clean;
    end
    check("short_pulse_rises", 32'(rises), 32'd0);
    expect_ev(1'b0, 1'b1, 32'd1, 8'd0);
    expect_ev(1'b0, 1'b0, 32'd0, 8'd0);
    A = 1'b1;
    tick(4);
    A = 1'b0;
    rises = 0;
    pa = a_clean;
    for (int i = 0; i < 25; i++) begin
      tick(1);
      if (a_clean && !pa) rises++;
      pa = a_clean;
    end
    check("long_pulse_rises", 32'(rises), 32'd1);
    check("glitch_position", position, 32'd0);

    // Both channels change together
    expect_ev(1'b1, 1'b0, 32'd0, 8'd1);
    move(1'b1, 1'b1);
    check("simul_err_cnt", 32'(err_cnt), 32'd1);
    check("simul_position", position, 32'd0);

    // Reset mid-count with both inputs high at position 7
    A = 1'b0;
    B = 1'b0;
    do_reset();
    expect_ev(1'b0, 1'b1, 32'd1, 8'd0); move(1'b1, 1'b0);
    expect_ev(1'b0, 1'b1, 32'd2, 8'd0); move(1'b1, 1'b1);
    expect_ev(1'b0, 1'b1, 32'd3, 8'd0); move(1'b0, 1'b1);
    expect_ev(1'b0, 1'b1, 32'd4, 8'd0); move(1'b0, 1'b0);
    expect_ev(1'b0, 1'b1, 32'd5, 8'd0); move(1'b1, 1'b0);
    expect_ev(1'b0, 1'b1, 32'd6, 8'd0); move(1'b1, 1'b1);
    expect_ev(1'b0, 1'b1, 32'd7, 8'd0); move(1'b0, 1'b1);
    check("pre_reset_position", position, 32'd7);
    A = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(1);
    check("midrst_position", position, 32'd0);
    check("midrst_a_clean", 32'(a_clean), 32'd0);
    check("midrst_step", 32'(step), 32'd0);
    reset = 1'b0;
    tick(12);
    check("postinit_a_clean", 32'(a_clean), 32'd1);
    check("postinit_b_clean", 32'(b_clean), 32'd1);
    check("postinit_position", position, 32'd0);
    check("postinit_err_cnt", 32'(err_cnt), 32'd0);

    // Error counter saturation
    A = 1'b0;
    B = 1'b0;
    do_reset();
    for (int i = 0; i < 260; i++) begin
      ec = (i < 255) ? 8'(i + 1) : 8'd255;
      expect_ev(1'b1, 1'b0, 32'd0, ec);
      A = ~A;
      B = ~B;
      tick(12);
    end
    check("sat_err_cnt", 32'(err_cnt), 32'd255);
    check("sat_position", position, 32'd0);

    tick(20);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
